// File: rtl/rf_alu_engine.sv
// -----------------------------------------------------------------------------
// rf_alu_engine
//   Register file with two combinational read ports feeding an ALU, whose result
//   is written back into the register file on the clock edge. Operand B is either
//   read port 2 or the immediate. After every reset, an init FSM scrubs all
//   2**ADDR_W entries to zero. While the scrub runs, busy is high and write
//   requests are dropped.
//
//   Build option RF_ALU_BYPASS_EN:
//     defined   - a one-entry last-write register (address/data/valid) is muxed
//                 onto both read ports. The array itself then only has to return
//                 data older than the most recent commit.
//     undefined - flop array with asynchronous read; no forwarding register.
//   Port behaviour is identical in both builds.
//
// Ports
//   clk         in   1       clock, all state on posedge
//   reset       in   1       synchronous, active-high
//   rfWrEn      in   1       commit aluOut to RF[wrAddr] (ignored while busy)
//   wrAddr      in   ADDR_W  destination register
//   rdAddr1     in   ADDR_W  read port 1 / operand A
//   rdAddr2     in   ADDR_W  read port 2 / operand B when !useImm
//   useImm      in   1       1: B = imm, 0: B = RF[rdAddr2]
//   aluFunc     in   FUNC_W  ALU operation
//   imm         in   DATA_W  immediate operand
//   rfDataOut1  out  DATA_W  RF[rdAddr1]
//   rfDataOut2  out  DATA_W  RF[rdAddr2]
//   aluOut      out  DATA_W  ALU(A,B)
//   zeroFlag    out  1       1 if the last committed result was zero
//   busy        out  1       1 while the init scrub runs
// -----------------------------------------------------------------------------
module rf_alu_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rfWrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    input  logic              useImm,
    input  logic [FUNC_W-1:0] aluFunc,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] rfDataOut1,
    output logic [DATA_W-1:0] rfDataOut2,
    output logic [DATA_W-1:0] aluOut,
    output logic              zeroFlag,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    localparam logic [FUNC_W-1:0] F_ADD  = FUNC_W'(4'b0000);
    localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(4'b0001);
    localparam logic [FUNC_W-1:0] F_SLT  = FUNC_W'(4'b0010);
    localparam logic [FUNC_W-1:0] F_AND  = FUNC_W'(4'b0100);
    localparam logic [FUNC_W-1:0] F_OR   = FUNC_W'(4'b0101);
    localparam logic [FUNC_W-1:0] F_XOR  = FUNC_W'(4'b0110);
    localparam logic [FUNC_W-1:0] F_NAND = FUNC_W'(4'b1100);
    localparam logic [FUNC_W-1:0] F_NOR  = FUNC_W'(4'b1101);
    localparam logic [FUNC_W-1:0] F_XNOR = FUNC_W'(4'b1110);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] scrub_ptr_q, scrub_ptr_d;
    logic              zero_q, zero_d;

    logic [DATA_W-1:0] rf_q [DEPTH];

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              wr_commit;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;

    // ------------------------------------------------------------------ read
    assign rd_addr[0] = rdAddr1;
    assign rd_addr[1] = rdAddr2;

`ifdef RF_ALU_BYPASS_EN
    logic [ADDR_W-1:0] last_addr_q;
    logic [DATA_W-1:0] last_data_q;
    logic              last_vld_q;

    // Tracks the most recent commit. The scrub never runs with a valid entry,
    // since reset clears last_vld_q and commits only happen in READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_vld_q  <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else if (wr_commit) begin
            last_vld_q  <= 1'b1;
            last_addr_q <= wrAddr;
            last_data_q <= alu_res;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
`ifdef RF_ALU_BYPASS_EN
            assign rd_data[gi] = (last_vld_q && (last_addr_q == rd_addr[gi]))
                                 ? last_data_q : rf_q[rd_addr[gi]];
`else
            assign rd_data[gi] = rf_q[rd_addr[gi]];
`endif
        end
    endgenerate

    assign rfDataOut1 = rd_data[0];
    assign rfDataOut2 = rd_data[1];

    // ------------------------------------------------------------------- ALU
    assign op_a = rd_data[0];
    assign op_b = useImm ? imm : rd_data[1];

    always_comb begin
        alu_res = op_b;
        case (aluFunc)
            F_ADD:   alu_res = op_a + op_b;
            F_SUB:   alu_res = op_a - op_b;
            F_SLT:   alu_res = ($signed(op_a) < $signed(op_b)) ? DATA_W'(1) : '0;
            F_AND:   alu_res = op_a & op_b;
            F_OR:    alu_res = op_a | op_b;
            F_XOR:   alu_res = op_a ^ op_b;
            F_NAND:  alu_res = ~(op_a & op_b);
            F_NOR:   alu_res = ~(op_a | op_b);
            F_XNOR:  alu_res = ~(op_a ^ op_b);
            default: alu_res = op_b;
        endcase
    end

    assign aluOut = alu_res;

    // --------------------------------------------------------- control / FSM
    assign wr_commit = rfWrEn && (state_q == ST_READY);

    always_comb begin
        state_d     = state_q;
        scrub_ptr_d = scrub_ptr_q;
        zero_d      = zero_q;
        rf_we       = 1'b0;
        rf_waddr    = wrAddr;
        rf_wdata    = alu_res;
        case (state_q)
            ST_INIT: begin
                // One entry per cycle; the all-ones pointer is the last one.
                rf_we       = 1'b1;
                rf_waddr    = scrub_ptr_q;
                rf_wdata    = '0;
                scrub_ptr_d = scrub_ptr_q + ADDR_W'(1);
                if (scrub_ptr_q == PTR_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (rfWrEn) begin
                    rf_we  = 1'b1;
                    zero_d = (alu_res == '0);
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (reset) begin
            // Reset during a scrub aborts it; the scrub restarts from entry 0.
            state_d     = ST_INIT;
            scrub_ptr_d = '0;
            zero_d      = 1'b0;
            rf_we       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            scrub_ptr_q <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scrub_ptr_q <= scrub_ptr_d;
            zero_q      <= zero_d;
        end
    end

    // The array is not reset, so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign zeroFlag = zero_q;
    assign busy     = (state_q == ST_INIT);

endmodule

// File: tb/tb_rf_alu_engine.sv
// -----------------------------------------------------------------------------
// tb_rf_alu_engine
//   Directed bench for rf_alu_engine (DATA_W=32, ADDR_W=4). The stimulus process
//   drives inputs 1 time unit after each rising edge. It then pushes the
//   hand-computed expected outputs for that cycle into a scoreboard queue. The
//   monitor process pops entries on the falling edge and compares only the
//   fields each entry enables.
// -----------------------------------------------------------------------------
module tb_rf_alu_engine;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int FUNC_W = 4;

    logic              clk;
    logic              reset;
    logic              rfWrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [ADDR_W-1:0] rdAddr1;
    logic [ADDR_W-1:0] rdAddr2;
    logic              useImm;
    logic [FUNC_W-1:0] aluFunc;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rfDataOut1;
    logic [DATA_W-1:0] rfDataOut2;
    logic [DATA_W-1:0] aluOut;
    logic              zeroFlag;
    logic              busy;

    rf_alu_engine #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .FUNC_W(FUNC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rfWrEn    (rfWrEn),
        .wrAddr    (wrAddr),
        .rdAddr1   (rdAddr1),
        .rdAddr2   (rdAddr2),
        .useImm    (useImm),
        .aluFunc   (aluFunc),
        .imm       (imm),
        .rfDataOut1(rfDataOut1),
        .rfDataOut2(rfDataOut2),
        .aluOut    (aluOut),
        .zeroFlag  (zeroFlag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enable bits for the fields an entry checks.
    localparam logic [4:0] C_BUSY = 5'b00001;
    localparam logic [4:0] C_ZF   = 5'b00010;
    localparam logic [4:0] C_O1   = 5'b00100;
    localparam logic [4:0] C_O2   = 5'b01000;
    localparam logic [4:0] C_ALU  = 5'b10000;

    typedef struct {
        string       name;
        logic [4:0]  en;
        logic        busy;
        logic        zf;
        logic [31:0] o1;
        logic [31:0] o2;
        logic [31:0] alu;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_chk(input string name, input logic [4:0] en, input logic b,
                           input logic zf, input logic [31:0] o1, input logic [31:0] o2,
                           input logic [31:0] alu);
        exp_t e;
        e.name = name;
        e.en   = en;
        e.busy = b;
        e.zf   = zf;
        e.o1   = o1;
        e.o2   = o2;
        e.alu  = alu;
        sb_q.push_back(e);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        exp_t m;
        int   bad;
        while (sb_q.size() > 0) begin
            m = sb_q.pop_front();
            bad = 0;
            if (m.en[0]) begin
                checks++;
                if (busy !== m.busy) begin
                    errors++; bad++;
                    $display("FAIL %s busy got %0b want %0b", m.name, busy, m.busy);
                end
            end
            if (m.en[1]) begin
                checks++;
                if (zeroFlag !== m.zf) begin
                    errors++; bad++;
                    $display("FAIL %s zeroFlag got %0b want %0b", m.name, zeroFlag, m.zf);
                end
            end
            if (m.en[2]) begin
                checks++;
                if (rfDataOut1 !== m.o1) begin
                    errors++; bad++;
                    $display("FAIL %s rfDataOut1 got %08h want %08h", m.name, rfDataOut1, m.o1);
                end
            end
            if (m.en[3]) begin
                checks++;
                if (rfDataOut2 !== m.o2) begin
                    errors++; bad++;
                    $display("FAIL %s rfDataOut2 got %08h want %08h", m.name, rfDataOut2, m.o2);
                end
            end
            if (m.en[4]) begin
                checks++;
                if (aluOut !== m.alu) begin
                    errors++; bad++;
                    $display("FAIL %s aluOut got %08h want %08h", m.name, aluOut, m.alu);
                end
            end
            if (bad == 0) begin
                $display("ok   %s busy=%0b zf=%0b o1=%08h o2=%08h alu=%08h",
                         m.name, busy, zeroFlag, rfDataOut1, rfDataOut2, aluOut);
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    typedef struct {
        logic [3:0]  func;
        logic [31:0] res;
    } alu_vec_t;

    alu_vec_t alu_tab[12];

    initial begin
        // A = RF[1] = 0xFFFFFFFF, B = imm = 0x00000F0F
        alu_tab[0]  = '{4'h0, 32'h0000_0F0E};
        alu_tab[1]  = '{4'h1, 32'hFFFF_F0F0};
        alu_tab[2]  = '{4'h4, 32'h0000_0F0F};
        alu_tab[3]  = '{4'h5, 32'hFFFF_FFFF};
        alu_tab[4]  = '{4'h6, 32'hFFFF_F0F0};
        alu_tab[5]  = '{4'hC, 32'hFFFF_F0F0};
        alu_tab[6]  = '{4'hD, 32'h0000_0000};
        alu_tab[7]  = '{4'hE, 32'h0000_0F0F};
        alu_tab[8]  = '{4'h2, 32'h0000_0001};
        alu_tab[9]  = '{4'h3, 32'h0000_0F0F};
        alu_tab[10] = '{4'h7, 32'h0000_0F0F};
        alu_tab[11] = '{4'hF, 32'h0000_0F0F};

        reset   = 1'b1;
        rfWrEn  = 1'b0;
        wrAddr  = '0;
        rdAddr1 = '0;
        rdAddr2 = '0;
        useImm  = 1'b0;
        aluFunc = '0;
        imm     = '0;
        tick();
        reset = 1'b0;

        // Scrub runs for 16 cycles. A write attempt to r3 is made throughout
        // this window and must be dropped.
        rfWrEn  = 1'b1;
        wrAddr  = 4'd3;
        rdAddr1 = 4'd3;
        useImm  = 1'b1;
        imm     = 32'd5;
        aluFunc = 4'h0;
        for (int i = 0; i < 16; i++) begin
            exp_chk($sformatf("scrub_busy%0d", i), C_BUSY | C_ZF, 1'b1, 1'b0, 0, 0, 0);
            tick();
        end
        rfWrEn = 1'b0;
        exp_chk("scrub_done", C_BUSY | C_ZF, 1'b0, 1'b0, 0, 0, 0);
        tick();

        for (int i = 0; i < 16; i++) begin
            rdAddr1 = 4'(i);
            rdAddr2 = 4'(15 - i);
            exp_chk($sformatf("rf_zero%0d", i), C_O1 | C_O2, 1'b0, 1'b0, 0, 0, 0);
            tick();
        end

        // RF[i] = RF[i] + 5
        useImm  = 1'b1;
        imm     = 32'd5;
        aluFunc = 4'h0;
        rfWrEn  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rdAddr1 = 4'(i);
            wrAddr  = 4'(i);
            exp_chk($sformatf("inc5_w%0d", i), C_O1 | C_ALU | C_BUSY, 1'b0, 1'b0, 0, 0, 32'd5);
            tick();
        end
        rfWrEn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdAddr2 = 4'(i);
            exp_chk($sformatf("inc5_r%0d", i), C_O2 | C_ZF, 1'b0, 1'b0, 0, 32'd5, 0);
            tick();
        end

        // r1 = 0xFFFFFFFF (pass-B). Reading r1 in the same cycle returns the old value.
        rfWrEn  = 1'b1;
        aluFunc = 4'hF;
        useImm  = 1'b1;
        imm     = 32'hFFFF_FFFF;
        wrAddr  = 4'd1;
        rdAddr1 = 4'd1;
        exp_chk("raw_old_r1", C_O1 | C_ALU, 1'b0, 1'b0, 32'd5, 0, 32'hFFFF_FFFF);
        tick();
        // r2 = 1. The new r1 is visible one cycle after its write.
        imm    = 32'd1;
        wrAddr = 4'd2;
        exp_chk("raw_new_r1", C_O1 | C_ALU, 1'b0, 1'b0, 32'hFFFF_FFFF, 0, 32'd1);
        tick();
        // r3 = r1 + r2 = 0
        useImm  = 1'b0;
        aluFunc = 4'h0;
        rdAddr1 = 4'd1;
        rdAddr2 = 4'd2;
        wrAddr  = 4'd3;
        exp_chk("add_wrap", C_O1 | C_O2 | C_ALU | C_ZF, 1'b0, 1'b0,
                32'hFFFF_FFFF, 32'd1, 32'd0);
        tick();
        // r4 = r2 - r1 = 2; zero flag from the previous commit is 1
        aluFunc = 4'h1;
        rdAddr1 = 4'd2;
        rdAddr2 = 4'd1;
        wrAddr  = 4'd4;
        exp_chk("sub_zf_set", C_O1 | C_O2 | C_ALU | C_ZF, 1'b0, 1'b1,
                32'd1, 32'hFFFF_FFFF, 32'd2);
        tick();
        rfWrEn  = 1'b0;
        rdAddr1 = 4'd4;
        rdAddr2 = 4'd3;
        exp_chk("sub_result", C_O1 | C_O2 | C_ZF, 1'b0, 1'b0, 32'd2, 32'd0, 0);
        tick();
        // r5 = r5 + 1, with the write and read addresses equal (read before write)
        rfWrEn  = 1'b1;
        aluFunc = 4'h0;
        useImm  = 1'b1;
        imm     = 32'd1;
        rdAddr1 = 4'd5;
        wrAddr  = 4'd5;
        exp_chk("rbw_same", C_O1 | C_ALU, 1'b0, 1'b0, 32'd5, 0, 32'd6);
        tick();
        rfWrEn = 1'b0;
        exp_chk("rbw_next", C_O1, 1'b0, 1'b0, 32'd6, 0, 0);
        tick();

        // SLT and pass-through
        useImm  = 1'b0;
        aluFunc = 4'h2;
        rdAddr1 = 4'd1;
        rdAddr2 = 4'd2;
        exp_chk("slt_neg_lt_pos", C_ALU, 1'b0, 1'b0, 0, 0, 32'd1);
        tick();
        rdAddr1 = 4'd2;
        rdAddr2 = 4'd1;
        exp_chk("slt_pos_lt_neg", C_ALU, 1'b0, 1'b0, 0, 0, 32'd0);
        tick();
        useImm  = 1'b1;
        rdAddr1 = 4'd4;
        imm     = 32'h8000_0000;
        exp_chk("slt_signed_min", C_ALU, 1'b0, 1'b0, 0, 0, 32'd0);
        tick();
        aluFunc = 4'hF;
        imm     = 32'h0000_00A5;
        exp_chk("pass_b_f", C_ALU, 1'b0, 1'b0, 0, 0, 32'h0000_00A5);
        tick();
        rdAddr1 = 4'd1;
        imm     = 32'h0000_0F0F;
        for (int i = 0; i < 12; i++) begin
            aluFunc = alu_tab[i].func;
            exp_chk($sformatf("alu_func%0h", alu_tab[i].func), C_ALU, 1'b0, 1'b0,
                    0, 0, alu_tab[i].res);
            tick();
        end

        // Set the zero flag, then reset: the flag must clear.
        rfWrEn  = 1'b1;
        aluFunc = 4'hF;
        imm     = 32'd0;
        wrAddr  = 4'd6;
        tick();
        rfWrEn = 1'b0;
        exp_chk("zf_before_reset", C_ZF | C_BUSY, 1'b0, 1'b1, 0, 0, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_chk("reset_state", C_ZF | C_BUSY, 1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) exp_chk($sformatf("scrub2_busy%0d", i), C_BUSY, 1'b1, 1'b0, 0, 0, 0);
            tick();
        end
        // Abort mid-scrub. The restarted scrub takes a full 16 cycles.
        reset = 1'b1;
        exp_chk("abort_busy", C_BUSY, 1'b1, 1'b0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_chk($sformatf("rescrub_busy%0d", i), C_BUSY | C_ZF, 1'b1, 1'b0, 0, 0, 0);
            tick();
        end
        rdAddr1 = 4'd4;
        rdAddr2 = 4'd12;
        exp_chk("rescrub_done", C_BUSY | C_O1 | C_O2, 1'b0, 1'b0, 32'd0, 32'd0, 0);
        tick();
        rdAddr1 = 4'd1;
        rdAddr2 = 4'd5;
        exp_chk("rescrub_zero", C_O1 | C_O2 | C_ZF, 1'b0, 1'b0, 32'd0, 32'd0, 0);
        tick();

        // Drain the scoreboard, with a bound on the wait.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain scoreboard left %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
